// File: rtl/codec_pkg.sv
// Shared definitions for the codec power-up sequencer.
// Holds the FSM state encoding (values double as the state_info display codes),
// the WM8731 register addresses and the default data written to each of them.
package codec_pkg;

    typedef enum logic [3:0] {
        StIdle    = 4'd0,
        StPowerup = 4'd1,
        StIssue   = 4'd2,
        StWait    = 4'd3,
        StGap     = 4'd4,
        StDone    = 4'd5,
        StError   = 4'd6
    } state_e;

    // WM8731 register addresses
    localparam logic [6:0] R_RESET  = 7'h0F;
    localparam logic [6:0] R_PWR    = 7'h06;
    localparam logic [6:0] R_APATH  = 7'h04;
    localparam logic [6:0] R_DPATH  = 7'h05;
    localparam logic [6:0] R_FMT    = 7'h07;
    localparam logic [6:0] R_SAMP   = 7'h08;
    localparam logic [6:0] R_ACTIVE = 7'h09;

    // Default 9-bit data for each register
    localparam logic [8:0] D_RESET  = 9'h000;  // reset
    localparam logic [8:0] D_PWR    = 9'h000;  // power all
    localparam logic [8:0] D_APATH  = 9'h012;  // DAC select, mic mute
    localparam logic [8:0] D_DPATH  = 9'h000;  // unmute DAC
    localparam logic [8:0] D_FMT    = 9'h002;  // I2S, 16-bit, slave
    localparam logic [8:0] D_SAMP   = 9'h000;  // normal mode, 48 kHz
    localparam logic [8:0] D_ACTIVE = 9'h001;  // active

    // Wire format sent to the I2C master: {reg_addr[6:0], reg_data[8:0]}
    function automatic logic [15:0] make_word(input logic [6:0] addr, input logic [8:0] data);
        return {addr, data};
    endfunction

endpackage

// File: rtl/codec_init_seq_if.sv
// Handshake/bus between the init sequencer and the byte-level I2C master.
//   i2c_start    : one-cycle request pulse from the sequencer
//   i2c_dev_addr : 7-bit slave address
//   i2c_word     : {reg_addr, reg_data}, stable from start until done
//   i2c_busy     : master is executing a transfer
//   i2c_done     : one-cycle completion pulse from the master
//   i2c_nack     : valid with i2c_done; slave NACKed some byte
// Modport master = sequencer side, slave = I2C master side.
interface codec_init_seq_if;
    logic        i2c_start;
    logic [6:0]  i2c_dev_addr;
    logic [15:0] i2c_word;
    logic        i2c_busy;
    logic        i2c_done;
    logic        i2c_nack;

    modport master (
        output i2c_start,
        output i2c_dev_addr,
        output i2c_word,
        input  i2c_busy,
        input  i2c_done,
        input  i2c_nack
    );

    modport slave (
        input  i2c_start,
        input  i2c_dev_addr,
        input  i2c_word,
        output i2c_busy,
        output i2c_done,
        output i2c_nack
    );
endinterface

// File: rtl/codec_reg_rom.sv
// Combinational table of codec register writes, in issue order.
//   index : table entry to read
//   word  : {reg_addr, reg_data}; zero for indices beyond the table
module codec_reg_rom
    import codec_pkg::*;
#(
    parameter int unsigned IDX_W = 3
) (
    input  logic [IDX_W-1:0] index,
    output logic [15:0]      word
);

    logic [31:0] index_ext;
    assign index_ext = 32'(index);

    always_comb begin
        word = 16'h0000;
        case (index_ext)
            32'd0:   word = make_word(R_RESET,  D_RESET);
            32'd1:   word = make_word(R_PWR,    D_PWR);
            32'd2:   word = make_word(R_APATH,  D_APATH);
            32'd3:   word = make_word(R_DPATH,  D_DPATH);
            32'd4:   word = make_word(R_FMT,    D_FMT);
            32'd5:   word = make_word(R_SAMP,   D_SAMP);
            32'd6:   word = make_word(R_ACTIVE, D_ACTIVE);
            default: word = 16'h0000;
        endcase
    end

endmodule

// File: rtl/codec_init_seq.sv
// Power-up configuration sequencer for a WM8731-class codec.
// Waits STARTUP_CYCLES after reset, then writes each table entry through the
// I2C master, retrying NACKed writes up to MAX_RETRIES times with a GAP_CYCLES
// pause before every retry and between entries.
//   clk        : system clock
//   reset      : asynchronous, active-low reset
//   restart    : one-cycle pulse, reruns the whole sequence (ignored mid-transfer)
//   i2c        : handshake/bus to the I2C master (master modport)
//   init_done  : all entries ACKed
//   init_error : an entry exhausted its retries
//   state_info : current state code for the display
module codec_init_seq
    import codec_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR       = 7'h1A,
    parameter int unsigned NUM_REGS       = 7,
    parameter logic [31:0] STARTUP_CYCLES = 32'd1_200_000,
    parameter logic [15:0] GAP_CYCLES     = 16'd1200,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    restart,
    codec_init_seq_if.master        i2c,
    output logic                    init_done,
    output logic                    init_error,
    output logic [3:0]              state_info
);

    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
    localparam logic [1:0] RETRY_MAX = 2'(MAX_RETRIES);
    // Terminal counts; a zero length still spends one cycle in the state.
    localparam logic [31:0] STARTUP_LAST =
        (STARTUP_CYCLES == 32'd0) ? 32'd0 : STARTUP_CYCLES - 32'd1;
    localparam logic [31:0] GAP_LAST =
        (GAP_CYCLES == 16'd0) ? 32'd0 : {16'd0, GAP_CYCLES} - 32'd1;

    state_e            state_q, state_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [1:0]        retry_q, retry_d;
    logic              adv_q, adv_d;
    logic              start_q, start_d;
    logic [15:0]       word_q, word_d;
    logic [15:0]       rom_word;

    codec_reg_rom #(
        .IDX_W (IDX_W)
    ) u_rom (
        .index (idx_q),
        .word  (rom_word)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 32'd0;
            idx_q   <= '0;
            retry_q <= 2'd0;
            adv_q   <= 1'b0;
            start_q <= 1'b0;
            word_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            retry_q <= retry_d;
            adv_q   <= adv_d;
            start_q <= start_d;
            word_q  <= word_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        retry_d = retry_q;
        adv_d   = adv_q;
        start_d = 1'b0;
        word_d  = word_q;

        // A transfer in flight is never abandoned, so restart is dropped in WAIT.
        if (restart && (state_q != StWait)) begin
            state_d = StPowerup;
            cnt_d   = 32'd0;
            idx_d   = '0;
            retry_d = 2'd0;
            adv_d   = 1'b0;
        end else begin
            case (state_q)
                StIdle: state_d = StPowerup;

                StPowerup: begin
                    if (cnt_q >= STARTUP_LAST) begin
                        cnt_d   = 32'd0;
                        idx_d   = '0;
                        retry_d = 2'd0;
                        state_d = StIssue;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end

                StIssue: begin
                    // Word and start register together, so the word is valid
                    // in the same cycle the pulse is seen.
                    word_d = rom_word;
                    if (!i2c.i2c_busy) begin
                        start_d = 1'b1;
                        state_d = StWait;
                    end
                end

                StWait: begin
                    if (i2c.i2c_done) begin
                        if (!i2c.i2c_nack) begin
                            adv_d   = 1'b1;
                            cnt_d   = 32'd0;
                            state_d = StGap;
                        end else if (retry_q < RETRY_MAX) begin
                            retry_d = retry_q + 2'd1;
                            adv_d   = 1'b0;
                            cnt_d   = 32'd0;
                            state_d = StGap;
                        end else begin
                            state_d = StError;
                        end
                    end
                end

                StGap: begin
                    if (cnt_q >= GAP_LAST) begin
                        cnt_d = 32'd0;
                        if (!adv_q) begin
                            state_d = StIssue;
                        end else if (idx_q == LAST_IDX) begin
                            state_d = StDone;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            retry_d = 2'd0;
                            state_d = StIssue;
                        end
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end

                StDone:  state_d = StDone;
                StError: state_d = StError;
                default: state_d = StIdle;
            endcase
        end
    end

    assign i2c.i2c_start    = start_q;
    assign i2c.i2c_word     = word_q;
    assign i2c.i2c_dev_addr = DEV_ADDR;
    assign init_done        = (state_q == StDone);
    assign init_error       = (state_q == StError);
    assign state_info       = state_q;

endmodule
